// File: rtl/jk_bank_sched.sv
// Two-requester round-robin scheduler driving a WIDTH-bit bank of JK cells.
// A granted command applies its latched J/K vector R+1 times, then pulses ack.
module jk_bank_sched #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] j0,
  input  logic [WIDTH-1:0] k0,
  input  logic [CNTW-1:0]  rpt0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] j1,
  input  logic [WIDTH-1:0] k1,
  input  logic [CNTW-1:0]  rpt1,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             win;

  // On a tie the requester that was not served last wins.
  assign win = req1 & (~req0 | ~last_q);

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    j_d     = j_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = APPLY;
          owner_d = win;
          last_d  = win;
          j_d     = win ? j1 : j0;
          k_d     = win ? k1 : k0;
          cnt_d   = win ? rpt1 : rpt0;
          busy_d  = 1'b1;
        end
      end
      APPLY: begin
        q_d = (j_q & ~q_q) | (~k_q & q_q);
        if (cnt_q == '0) begin
          state_d = DONE;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      j_q     <= j_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign q     = q_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed bench for jk_bank_sched: per-edge model of the JK bank plus a
// scoreboard of expected (owner, final q) entries popped on each ack pulse.
module tb_jk_bank_sched;

  logic       clk, rst;
  logic       req0, req1, ack0, ack1, busy, owner;
  logic [7:0] j0, k0, j1, k1, q;
  logic [3:0] rpt0, rpt1;

  typedef struct {
    logic       who;
    logic [7:0] q;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq;
  int         checks = 0;
  int         errors = 0;

  jk_bank_sched #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .j0(j0), .k0(k0), .rpt0(rpt0), .ack0(ack0),
    .req1(req1), .j1(j1), .k1(k1), .rpt1(rpt1), .ack1(ack1),
    .q(q), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] jk_apply(input logic [7:0] cur, input logic [7:0] j,
                                          input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = cur[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~cur[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] model_run(input logic [7:0] cur, input logic [7:0] j,
                                           input logic [7:0] k, input logic [3:0] r);
    logic [7:0] t = cur;
    for (int n = 0; n <= int'(r); n++) t = jk_apply(t, j, k);
    return t;
  endfunction

  task automatic drive(input logic who, input logic [7:0] j, input logic [7:0] k,
                       input logic [3:0] r);
    if (!who) begin req0 = 1'b1; j0 = j; k0 = k; rpt0 = r; end
    else      begin req1 = 1'b1; j1 = j; k1 = k; rpt1 = r; end
  endtask

  // Called at a falling edge; runs one command alone with edge-exact checks.
  task automatic run_one(input logic who, input logic [7:0] j, input logic [7:0] k,
                         input logic [3:0] r, input bit jchg);
    exp_t ex;
    drive(who, j, k, r);
    ex.who = who;
    ex.q   = model_run(mq, j, k, r);
    sb.push_back(ex);
    @(negedge clk);
    check("grant_busy", busy, 1);
    check("grant_owner", owner, who);
    check("grant_q", q, mq);
    if (jchg) begin
      if (who) j1 = ~j; else j0 = ~j;
    end
    for (int n = 1; n <= int'(r) + 1; n++) begin
      @(negedge clk);
      mq = jk_apply(mq, j, k);
      check("apply_q", q, mq);
      if (n <= int'(r)) check("early_ack", {ack1, ack0}, 0);
    end
    check("ack_pulse", who ? ack1 : ack0, 1);
    check("ack_other", who ? ack0 : ack1, 0);
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      check("sb_owner", owner, ex.who);
      check("sb_q", q, ex.q);
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    check("ack_fall", {ack1, ack0}, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    exp_t ex;
    int   rem0, rem1;
    bit   rearm0, rearm1;

    rst = 1'b1;
    req0 = 0; req1 = 0; j0 = 0; k0 = 0; j1 = 0; k1 = 0; rpt0 = 0; rpt1 = 0;
    mq = 8'h00;
    #1;
    check("rst_q", q, 8'h00);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    @(negedge clk);
    rst = 1'b0;

    // Set/clear, then repeated toggle from requester 1.
    run_one(1'b0, 8'hF0, 8'h0F, 4'd0, 1'b0);
    check("setclr_q", q, 8'hF0);
    run_one(1'b1, 8'hFF, 8'hFF, 4'd2, 1'b0);
    check("toggle_q", q, 8'h0F);
    check("toggle_owner", owner, 1);

    // Reset in the middle of APPLY abandons the command.
    drive(1'b0, 8'hFF, 8'hFF, 4'd7);
    ex.who = 1'b0;
    ex.q   = model_run(mq, 8'hFF, 8'hFF, 4'd7);
    sb.push_back(ex);
    @(negedge clk);
    check("mid_busy", busy, 1);
    repeat (2) begin
      @(negedge clk);
      mq = jk_apply(mq, 8'hFF, 8'hFF);
      check("mid_q", q, mq);
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack0, 0);
    check("mid_rst_owner", owner, 0);
    sb.delete();
    mq = 8'h00;
    @(negedge clk);
    check("mid_rst_hold_q", q, 8'h00);
    check("mid_rst_hold_ack", ack0, 0);
    rst = 1'b0;
    run_one(1'b0, 8'hFF, 8'hFF, 4'd7, 1'b0);
    check("regrant_q", q, 8'h00);

    // Tie arbitration straight after reset, with both requesters re-requesting once.
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq = 8'h00;
    ex.who = 1'b0; ex.q = 8'h01; sb.push_back(ex);
    ex.who = 1'b1; ex.q = 8'h81; sb.push_back(ex);
    ex.who = 1'b0; ex.q = 8'h81; sb.push_back(ex);
    ex.who = 1'b1; ex.q = 8'h81; sb.push_back(ex);
    drive(1'b0, 8'h01, 8'h00, 4'd0);
    drive(1'b1, 8'h80, 8'h00, 4'd0);
    rem0 = 1; rem1 = 1; rearm0 = 0; rearm1 = 0;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      if (rearm0) begin req0 = 1'b1; rearm0 = 0; end
      if (rearm1) begin req1 = 1'b1; rearm1 = 0; end
      if (ack0 || ack1) begin
        check("tie_one_ack", ack0 & ack1, 0);
        ex = sb.pop_front();
        check("tie_who", ack1, ex.who);
        check("tie_owner", owner, ex.who);
        check("tie_q", q, ex.q);
        if (ack0) begin
          req0 = 1'b0;
          if (rem0 > 0) begin rem0--; rearm0 = 1; end
        end
        if (ack1) begin
          req1 = 1'b0;
          if (rem1 > 0) begin rem1--; rearm1 = 1; end
        end
      end
    end
    check("tie_drained", sb.size(), 0);
    @(negedge clk);
    check("tie_idle", busy, 0);
    check("tie_final_q", q, 8'h81);
    mq = 8'h81;

    // Load 0x5A, then hold it for 16 apply edges while j1 changes underneath.
    run_one(1'b1, 8'h5A, 8'hA5, 4'd0, 1'b0);
    check("load_q", q, 8'h5A);
    run_one(1'b1, 8'h00, 8'h00, 4'd15, 1'b1);
    check("hold_q", q, 8'h5A);
    check("hold_owner", owner, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_sched.md
# jk_bank_sched

Two-requester round-robin scheduler that owns a WIDTH-bit bank of JK flip-flop cells and applies JK command vectors to it on behalf of either requester. A requester holds a JK vector and a repeat count on a req/ack handshake. The scheduler grants one requester at a time, applies the vector to the bank for the requested number of consecutive cycles, and acknowledges completion. It sits between control logic that needs set/clear/toggle access to shared state bits and the JK cell bank that holds those bits.

## Interface
- WIDTH, 8: number of JK cells in the bank.
- CNTW, 4: width of the repeat-count field.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 request; held until ack0 is sampled high.
- j0  in  WIDTH  requester 0 J vector; stable while req0 is high.
- k0  in  WIDTH  requester 0 K vector; stable while req0 is high.
- rpt0  in  CNTW  requester 0 repeat count R; vector is applied R+1 times.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, j1, k1, rpt1, ack1: same as above, for requester 1.
- q  out  WIDTH  JK bank state.
- busy  out  1  high while a command is in progress.
- owner  out  1  requester currently or most recently granted.

## Operation
- Per-bit JK rule on each apply cycle, for bit i:
  - {j,k}=00: hold q[i].
  - 01: q[i]<=0.
  - 10: q[i]<=1.
  - 11: q[i]<=~q[i].
- FSM states: IDLE, APPLY, DONE.
- IDLE, no request: remain in IDLE.
- IDLE with req0 or req1 high:
  - Latch the j, k and rpt of the winner into internal registers.
  - Set owner to the winner and load cnt<=rpt.
  - Go to APPLY.
- Arbitration:
  - Single request: that request wins.
  - Both requests: the requester that is not the last-served one wins.
  - last is updated at grant. Reset value of last is 1, so req0 wins the first tie.
- APPLY:
  - Each cycle, apply the latched J/K to q.
  - If cnt==0, go to DONE; otherwise cnt<=cnt-1.
  - Inputs are not resampled during APPLY; changes on j/k/rpt have no effect.
- DONE:
  - ack[owner]=1 for exactly this one cycle.
  - q holds.
  - Go to IDLE.
- busy=1 in APPLY and DONE, 0 in IDLE.
- Requester rule: deassert req at the first edge where ack is sampled high. It may reassert it the next cycle.
- A req that is dropped before grant is ignored; no ack is issued for it.
- Reset (asynchronous, any state, including mid-APPLY):
  - q=0, state=IDLE, ack0=ack1=0, busy=0, owner=0, last=1, cnt=0.
  - The interrupted command is abandoned and never acked.
  - A req still high after rst falls is granted as new.

## Timing
- Edge E0, IDLE sampling a req: grant and latch. busy rises after E0.
- Edges E1 to E(R+1): q updates once per edge (R+1 updates in total).
- At E(R+1): state becomes DONE and ack rises.
- At E(R+2): ack falls and state returns to IDLE.
- Request-to-ack latency is R+1 edges after grant. The earliest next grant is at E(R+3).
- Back-to-back, with both requesters permanently requesting (each re-requesting after its ack): grants alternate 0,1,0,1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst mid-cycle with no clock edge -> immediately q=0x00, ack0=ack1=0, busy=0, owner=0.
- Set/clear: q=0x00, then req0 with j0=0xF0, k0=0x0F, rpt0=0 -> q=0xF0 after E1; ack0 high for one cycle after E1; busy low after E2.
- Repeated toggle: q=0xF0, then req1 with j1=k1=0xFF, rpt1=2 -> q goes 0x0F, 0xF0, 0x0F on E1..E3; single ack1 pulse; owner=1.
- Tie arbitration after reset:
  - Stimulus: req0 and req1 both high.
  - req0 (j=0x01, k=0, rpt=0) is served first; req1 (j=0x80, k=0, rpt=0) is served next; final q=0x81.
  - Both re-request -> order is 0 then 1 again.
- Reset mid-APPLY: req0 with j0=k0=0xFF, rpt0=7, rst pulsed at E3 -> q=0x00, busy=0, no ack0. With req0 still high after reset, the command is re-granted and completes with ack0 after 8 updates.
- Hold with maximum repeat: q=0x5A, req1 with j1=k1=0x00, rpt1=15 -> q stays 0x5A throughout; ack1 after 16 apply edges (E16); changing j1 during APPLY has no effect.
